// File: rtl/riscv_defines.sv
// rtl/riscv_defines.sv - shared register file constants and types
package riscv_defines;

  localparam int WORD_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int N_OF_REGS  = 2 ** ADDR_WIDTH;

  typedef logic [WORD_WIDTH-1:0] word_t;
  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;

  // x0 is hardwired to zero and never tracked by the scoreboard
  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register busy bits for multi-cycle producers
module reg_scoreboard
  import riscv_defines::*;
#(
  parameter int ADDR_W = ADDR_WIDTH,
  parameter int N_REGS = N_OF_REGS,
  parameter int N_RD   = 3,
  parameter int N_WR   = 2,
  parameter int BYP    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_RD*ADDR_W-1:0] read_addr_i,
  output logic [N_RD-1:0]        read_busy_o,
  input  logic [N_WR-1:0]        write_en_i,
  input  logic [N_WR*ADDR_W-1:0] write_addr_i,
  input  logic [N_WR-1:0]        write_clr_i,
  input  logic                   reserve_en_i,
  input  logic [ADDR_W-1:0]      reserve_addr_i,
  output logic                   reserve_ok_o,
  output logic [N_REGS-1:0]      busy_vec_o
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [N_REGS-1:0] busy_q;
  logic [N_REGS-1:0] clr_mask;
  logic [N_REGS-1:0] set_mask;

  // One-hot-per-register mask of clearing writes this cycle (x0 excluded)
  always_comb begin
    clr_mask = '0;
    for (int w = 0; w < N_WR; w++) begin
      if (write_en_i[w] && write_clr_i[w] &&
          write_addr_i[w*ADDR_W +: ADDR_W] != ZERO_ADDR) begin
        clr_mask[write_addr_i[w*ADDR_W +: ADDR_W]] = 1'b1;
      end
    end
  end

  // Reservation is judged against registered state only, so a clearing
  // write in the same cycle cannot make a busy register reservable
  always_comb begin
    set_mask     = '0;
    reserve_ok_o = 1'b0;
    if (reserve_en_i) begin
      if (reserve_addr_i == ZERO_ADDR) begin
        reserve_ok_o = 1'b1;
      end else if (!busy_q[reserve_addr_i]) begin
        reserve_ok_o             = 1'b1;
        set_mask[reserve_addr_i] = 1'b1;
      end
    end
  end

  // Busy bits: clears only affect busy registers, sets only idle ones
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= (busy_q & ~clr_mask) | set_mask;
    end
  end

  assign busy_vec_o = busy_q;

  // Per read port busy lookup, masked by a same-cycle clear when bypassing
  for (genvar r = 0; r < N_RD; r++) begin : g_rd_busy
    logic [ADDR_W-1:0] ra;
    logic              clr_hit;
    assign ra      = read_addr_i[r*ADDR_W +: ADDR_W];
    assign clr_hit = (BYP != 0) && clr_mask[ra];
    assign read_busy_o[r] = busy_q[ra] && !clr_hit;
  end

endmodule

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-port register file with bypass and busy scoreboard
module reg_file_mp
  import riscv_defines::*;
#(
  parameter int WORD_WIDTH = riscv_defines::WORD_WIDTH,
  parameter int ADDR_WIDTH = riscv_defines::ADDR_WIDTH,
  parameter int N_OF_REGS  = 2 ** ADDR_WIDTH,
  parameter int N_READ     = 3,
  parameter int N_WRITE    = 2,
  parameter int BYPASS     = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_READ*ADDR_WIDTH-1:0]  read_addr_i,
  output logic [N_READ*WORD_WIDTH-1:0]  read_data_o,
  output logic [N_READ-1:0]             read_busy_o,
  input  logic [N_WRITE-1:0]            write_en_i,
  input  logic [N_WRITE*ADDR_WIDTH-1:0] write_addr_i,
  input  logic [N_WRITE*WORD_WIDTH-1:0] write_data_i,
  input  logic [N_WRITE-1:0]            write_clr_i,
  input  logic                          reserve_en_i,
  input  logic [ADDR_WIDTH-1:0]         reserve_addr_i,
  output logic                          reserve_ok_o,
  output logic [N_OF_REGS-1:0]          busy_vec_o
);

  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);

  logic [WORD_WIDTH-1:0] mem_q   [N_OF_REGS];
  logic [WORD_WIDTH-1:0] wr_data [N_OF_REGS];
  logic [N_OF_REGS-1:0]  wr_hit;

  // Write priority mux: scanning ports upward lets the highest index win
  always_comb begin
    wr_hit = '0;
    for (int r = 0; r < N_OF_REGS; r++) begin
      wr_data[r] = mem_q[r];
    end
    for (int w = 0; w < N_WRITE; w++) begin
      if (write_en_i[w] && write_addr_i[w*ADDR_WIDTH +: ADDR_WIDTH] != ZERO_ADDR) begin
        wr_hit[write_addr_i[w*ADDR_WIDTH +: ADDR_WIDTH]]  = 1'b1;
        wr_data[write_addr_i[w*ADDR_WIDTH +: ADDR_WIDTH]] = write_data_i[w*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

  // Storage array; reset wins over any write presented in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < N_OF_REGS; r++) begin
        mem_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < N_OF_REGS; r++) begin
        if (wr_hit[r]) begin
          mem_q[r] <= wr_data[r];
        end
      end
    end
  end

  // Per read port: storage, optionally overridden by a same-cycle write
  for (genvar p = 0; p < N_READ; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic [WORD_WIDTH-1:0] rdata;
    assign ra = read_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];

    // Bypass select; x0 is forced to zero regardless of storage or writes
    always_comb begin
      rdata = mem_q[ra];
      if (BYPASS != 0) begin
        for (int w = 0; w < N_WRITE; w++) begin
          if (write_en_i[w] && write_addr_i[w*ADDR_WIDTH +: ADDR_WIDTH] == ra) begin
            rdata = write_data_i[w*WORD_WIDTH +: WORD_WIDTH];
          end
        end
      end
      if (ra == ZERO_ADDR) begin
        rdata = '0;
      end
    end

    assign read_data_o[p*WORD_WIDTH +: WORD_WIDTH] = rdata;
  end

  reg_scoreboard #(
    .ADDR_W (ADDR_WIDTH),
    .N_REGS (N_OF_REGS),
    .N_RD   (N_READ),
    .N_WR   (N_WRITE),
    .BYP    (BYPASS)
  ) u_scoreboard (
    .clk            (clk),
    .rst            (rst),
    .read_addr_i    (read_addr_i),
    .read_busy_o    (read_busy_o),
    .write_en_i     (write_en_i),
    .write_addr_i   (write_addr_i),
    .write_clr_i    (write_clr_i),
    .reserve_en_i   (reserve_en_i),
    .reserve_addr_i (reserve_addr_i),
    .reserve_ok_o   (reserve_ok_o),
    .busy_vec_o     (busy_vec_o)
  );

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - scoreboard bench for reg_file_mp, bypass and registered builds
module tb_reg_file_mp;

  localparam int NR = 3;
  localparam int NW = 2;

  logic          clk = 1'b0;
  logic          s_rst;
  logic [14:0]   s_ra;
  logic [1:0]    s_we;
  logic [9:0]    s_wa;
  logic [63:0]   s_wd;
  logic [1:0]    s_wc;
  logic          s_re;
  logic [4:0]    s_rsa;

  logic [95:0]   rd_b, rd_n;
  logic [2:0]    rb_b, rb_n;
  logic          ok_b, ok_n;
  logic [31:0]   bv_b, bv_n;

  always #5 clk = ~clk;

  reg_file_mp #(.BYPASS(1)) dut_byp (
    .clk(clk), .rst(s_rst), .read_addr_i(s_ra), .read_data_o(rd_b), .read_busy_o(rb_b),
    .write_en_i(s_we), .write_addr_i(s_wa), .write_data_i(s_wd), .write_clr_i(s_wc),
    .reserve_en_i(s_re), .reserve_addr_i(s_rsa), .reserve_ok_o(ok_b), .busy_vec_o(bv_b)
  );

  reg_file_mp #(.BYPASS(0)) dut_nob (
    .clk(clk), .rst(s_rst), .read_addr_i(s_ra), .read_data_o(rd_n), .read_busy_o(rb_n),
    .write_en_i(s_we), .write_addr_i(s_wa), .write_data_i(s_wd), .write_clr_i(s_wc),
    .reserve_en_i(s_re), .reserve_addr_i(s_rsa), .reserve_ok_o(ok_n), .busy_vec_o(bv_n)
  );

  typedef struct {
    logic [95:0] rd_b;
    logic [95:0] rd_n;
    logic [2:0]  rb_b;
    logic [2:0]  rb_n;
    logic        ok;
    logic [31:0] bv;
    logic        dir_v;
    logic [31:0] dir_b;
    logic [31:0] dir_n;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state: architectural register values and pending producers
  logic [31:0] m_regs [32];
  bit          m_busy [32];

  task automatic check(input string name, input logic [95:0] got, input logic [95:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  function automatic logic [31:0] model_read(input int a, input bit byp);
    logic [31:0] v;
    if (a == 0) return 32'h0;
    v = m_regs[a];
    if (byp) begin
      for (int w = 0; w < NW; w++)
        if (s_we[w] && int'(s_wa[w*5 +: 5]) == a) v = s_wd[w*32 +: 32];
    end
    return v;
  endfunction

  function automatic bit clearing(input int a);
    for (int w = 0; w < NW; w++)
      if (s_we[w] && s_wc[w] && int'(s_wa[w*5 +: 5]) == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic idle();
    s_rst = 1'b0; s_ra = '0; s_we = '0; s_wa = '0; s_wd = '0; s_wc = '0; s_re = 1'b0; s_rsa = '0;
  endtask

  // Drive the staged stimulus, predict outputs, then advance the model
  logic [14:0] st_ra; logic [1:0] st_we, st_wc; logic [9:0] st_wa; logic [63:0] st_wd;
  logic st_rst, st_re; logic [4:0] st_rsa;

  task automatic cycle(input bit dv, input logic [31:0] db, input logic [31:0] dn);
    exp_t e;
    bit   ok;
    int   ra;
    @(posedge clk);
    #1;
    s_rst = st_rst; s_ra = st_ra; s_we = st_we; s_wa = st_wa; s_wd = st_wd;
    s_wc = st_wc; s_re = st_re; s_rsa = st_rsa;
    for (int p = 0; p < NR; p++) begin
      ra = int'(s_ra[p*5 +: 5]);
      e.rd_b[p*32 +: 32] = model_read(ra, 1'b1);
      e.rd_n[p*32 +: 32] = model_read(ra, 1'b0);
      e.rb_b[p] = m_busy[ra] && !clearing(ra);
      e.rb_n[p] = m_busy[ra];
    end
    ok = s_re && (s_rsa == 5'd0 || !m_busy[s_rsa]);
    e.ok = ok;
    for (int r = 0; r < 32; r++) e.bv[r] = m_busy[r];
    e.dir_v = dv; e.dir_b = db; e.dir_n = dn;
    exp_q.push_back(e);
    if (s_rst) begin
      for (int r = 0; r < 32; r++) begin m_regs[r] = 0; m_busy[r] = 0; end
    end else begin
      for (int r = 1; r < 32; r++) if (clearing(r)) m_busy[r] = 0;
      if (ok && s_rsa != 5'd0) m_busy[s_rsa] = 1;
      for (int w = 0; w < NW; w++)
        if (s_we[w] && s_wa[w*5 +: 5] != 5'd0) m_regs[s_wa[w*5 +: 5]] = s_wd[w*32 +: 32];
    end
  endtask

  task automatic stage_idle();
    st_rst = 0; st_ra = '0; st_we = '0; st_wa = '0; st_wd = '0; st_wc = '0; st_re = 0; st_rsa = '0;
  endtask

  // Monitor: outputs are stable mid-cycle, compare against the oldest prediction
  exp_t me;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      me = exp_q.pop_front();
      check("rdata_byp", 96'(rd_b), me.rd_b);
      check("rdata_reg", 96'(rd_n), me.rd_n);
      check("rbusy_byp", 96'(rb_b), 96'(me.rb_b));
      check("rbusy_reg", 96'(rb_n), 96'(me.rb_n));
      check("reserve_ok_byp", 96'(ok_b), 96'(me.ok));
      check("reserve_ok_reg", 96'(ok_n), 96'(me.ok));
      check("busy_vec_byp", 96'(bv_b), 96'(me.bv));
      check("busy_vec_reg", 96'(bv_n), 96'(me.bv));
      if (me.dir_v) begin
        check("directed_rd0_byp", 96'(rd_b[31:0]), 96'(me.dir_b));
        check("directed_rd0_reg", 96'(rd_n[31:0]), 96'(me.dir_n));
      end
    end
  end

  initial begin
    for (int r = 0; r < 32; r++) begin m_regs[r] = 0; m_busy[r] = 0; end
    idle();
    s_rst = 1'b1;
    @(posedge clk);
    #1;
    stage_idle();

    // Reset: preload x1..x31 then one reset edge
    for (int n = 1; n < 32; n++) begin
      stage_idle(); st_we = 2'b01; st_wa[4:0] = 5'(n); st_wd[31:0] = 32'hA5A5_0000 + n;
      st_ra = {5'(n), 5'(n), 5'(n - 1)};
      cycle(0, 0, 0);
    end
    stage_idle(); st_re = 1; st_rsa = 5'd12; cycle(0, 0, 0);
    stage_idle(); st_rst = 1; st_ra = {5'd31, 5'd2, 5'd1}; st_we = 2'b11; st_wa = {5'd6, 5'd6};
    cycle(1, 32'hA5A5_0001, 32'hA5A5_0001);
    stage_idle(); st_ra = {5'd31, 5'd12, 5'd1}; cycle(1, 0, 0);

    // Write collision on x5
    stage_idle(); st_we = 2'b11; st_wa = {5'd5, 5'd5}; st_wd = {32'h2222, 32'h1111};
    st_ra[4:0] = 5'd5; cycle(1, 32'h2222, 32'h0);
    stage_idle(); st_ra[4:0] = 5'd5; cycle(1, 32'h2222, 32'h2222);

    // Zero register
    stage_idle(); st_we = 2'b01; st_wd[31:0] = 32'hDEAD_BEEF; st_re = 1; cycle(1, 0, 0);
    stage_idle(); cycle(1, 0, 0);

    // Scoreboard on x7
    stage_idle(); st_re = 1; st_rsa = 5'd7; cycle(0, 0, 0);
    stage_idle(); st_re = 1; st_rsa = 5'd7; st_ra[9:5] = 5'd7; cycle(0, 0, 0);
    stage_idle(); st_we = 2'b10; st_wc = 2'b10; st_wa[9:5] = 5'd7; st_wd[63:32] = 32'h55;
    st_re = 1; st_rsa = 5'd7; st_ra[4:0] = 5'd7; cycle(1, 32'h55, 32'h0);
    stage_idle(); st_ra[4:0] = 5'd7; cycle(1, 32'h55, 32'h55);

    // Reset mid-operation
    stage_idle(); st_re = 1; st_rsa = 5'd3; cycle(0, 0, 0);
    stage_idle(); st_re = 1; st_rsa = 5'd4; cycle(0, 0, 0);
    stage_idle(); st_rst = 1; cycle(0, 0, 0);
    stage_idle(); st_re = 1; st_rsa = 5'd3; cycle(0, 0, 0);
    stage_idle(); st_ra = {5'd4, 5'd3, 5'd0}; cycle(0, 0, 0);

    // Registered-only read of a same-cycle write
    stage_idle(); st_we = 2'b01; st_wa[4:0] = 5'd9; st_wd[31:0] = 32'h1234;
    st_ra[4:0] = 5'd9; cycle(1, 32'h1234, 32'h0);
    stage_idle(); st_ra[4:0] = 5'd9; cycle(1, 32'h1234, 32'h1234);

    // Random traffic concentrated on a few registers to provoke collisions
    for (int i = 0; i < 3000; i++) begin
      stage_idle();
      st_rst = ($urandom_range(0, 99) == 0);
      for (int p = 0; p < NR; p++) st_ra[p*5 +: 5] = 5'($urandom_range(0, 7));
      for (int w = 0; w < NW; w++) begin
        st_wa[w*5 +: 5]  = 5'($urandom_range(0, 7));
        st_wd[w*32 +: 32] = $urandom;
      end
      st_we  = 2'($urandom);
      st_wc  = 2'($urandom);
      st_re  = 1'($urandom);
      st_rsa = 5'($urandom_range(0, 7));
      cycle(0, 0, 0);
    end

    @(posedge clk);
    #1;
    idle();
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d predictions left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
